// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns (active low, g..a), special codes and reader FSM states
package seg7_pkg;
  localparam logic [6:0] SEG7_PAT_0 = 7'h40;
  localparam logic [6:0] SEG7_PAT_1 = 7'h79;
  localparam logic [6:0] SEG7_PAT_2 = 7'h24;
  localparam logic [6:0] SEG7_PAT_3 = 7'h30;
  localparam logic [6:0] SEG7_PAT_4 = 7'h19;
  localparam logic [6:0] SEG7_PAT_5 = 7'h12;
  localparam logic [6:0] SEG7_PAT_6 = 7'h02;
  localparam logic [6:0] SEG7_PAT_7 = 7'h78;
  localparam logic [6:0] SEG7_PAT_8 = 7'h00;
  localparam logic [6:0] SEG7_PAT_9 = 7'h10;
  localparam logic [6:0] SEG7_PAT_A = 7'h3F;
  localparam logic [6:0] SEG7_PAT_B = 7'h7F;
  localparam logic [6:0] SEG7_PAT_C = 7'h46;
  localparam logic [6:0] SEG7_PAT_D = 7'h21;
  localparam logic [6:0] SEG7_PAT_E = 7'h06;
  localparam logic [6:0] SEG7_PAT_F = 7'h0E;
  localparam logic [3:0] SEG7_CODE_DASH = 4'hA;
  localparam logic [3:0] SEG7_CODE_BLANK = 4'hB;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} seg7_state_t;
endpackage

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: inverse segment map, seg[6:0] (active low) -> {valid, code}
//   seg   in  7  segment pattern g..a, active low
//   valid out 1  pattern is one of the 16 known glyphs
//   code  out 4  recovered code (0 when invalid)
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] code
);
  always_comb begin
    valid = 1'b1;
    code = 4'h0;
    case (seg)
      SEG7_PAT_0: code = 4'h0;
      SEG7_PAT_1: code = 4'h1;
      SEG7_PAT_2: code = 4'h2;
      SEG7_PAT_3: code = 4'h3;
      SEG7_PAT_4: code = 4'h4;
      SEG7_PAT_5: code = 4'h5;
      SEG7_PAT_6: code = 4'h6;
      SEG7_PAT_7: code = 4'h7;
      SEG7_PAT_8: code = 4'h8;
      SEG7_PAT_9: code = 4'h9;
      SEG7_PAT_A: code = SEG7_CODE_DASH;
      SEG7_PAT_B: code = SEG7_CODE_BLANK;
      SEG7_PAT_C: code = 4'hC;
      SEG7_PAT_D: code = 4'hD;
      SEG7_PAT_E: code = 4'hE;
      SEG7_PAT_F: code = 4'hF;
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers per-digit codes from a scanned active-low 7-segment bus
//   clk, rst     clock, synchronous active-high reset
//   seg_in       segment bus, active low, [7]=dp, [6:0]=g..a
//   dig_sel      active-low one-hot digit select
//   digit_val    recovered codes, digit i at [4i+3:4i]
//   digit_ok     digit i holds a valid code
//   frame_valid  one-cycle pulse once every digit has been captured
//   pat_err      sticky unrecognised-pattern flag
//   digit_dp     decimal point per digit (only when SEG7_DP_CAPTURE_EN is defined)
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    frame_valid,
  output logic                    pat_err
`ifdef SEG7_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]   digit_dp
`endif
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int LW = NUM_DIGITS + 8;
  seg7_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] lat, cur;
  logic [7:0] seg_cmp;
  logic sel_ok, same, cap, lk_valid;
  logic [3:0] lk_code;
  logic [IW-1:0] idx;
  logic [NUM_DIGITS-1:0] seen;
`ifdef SEG7_DP_CAPTURE_EN
  assign seg_cmp = seg_in;
`else
  // dp bit is masked out so it cannot disturb the stability compare
  logic unused_dp;
  assign unused_dp = seg_in[7];
  assign seg_cmp = {1'b0, seg_in[6:0]};
`endif
  assign cur = {dig_sel, seg_cmp};
  assign sel_ok = $countones(~dig_sel) == 1;
  assign same = cur == lat;
  seg7_pattern_lookup u_lookup (
    .seg(seg_in[6:0]),
    .valid(lk_valid),
    .code(lk_code)
  );
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!dig_sel[i]) idx = IW'(i);
  end
  // any new valid value restarts the count at 1, so SETTLE_CYC=1 captures immediately
  always_comb begin
    state_n = IDLE;
    cnt_n = '0;
    cap = 1'b0;
    if (sel_ok && state == HOLD && same) begin
      state_n = HOLD;
      cnt_n = cnt;
    end else if (sel_ok) begin
      cnt_n = (state == SETTLE && same) ? cnt + 1'b1 : CW'(1);
      cap = cnt_n == CW'(SETTLE_CYC);
      state_n = cap ? HOLD : SETTLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      lat <= '0;
      seen <= '0;
      frame_valid <= 1'b0;
      pat_err <= 1'b0;
      digit_val <= '0;
      digit_ok <= '0;
`ifdef SEG7_DP_CAPTURE_EN
      digit_dp <= '0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lat <= sel_ok ? cur : lat;
      // a full mask pulses frame_valid and restarts, keeping any capture on this edge
      frame_valid <= &seen;
      seen <= (&seen ? '0 : seen) | (cap ? ~dig_sel : '0);
      if (cap) begin
        digit_ok[idx] <= lk_valid;
        pat_err <= pat_err | ~lk_valid;
        if (lk_valid) digit_val[idx*4 +: 4] <= lk_code;
`ifdef SEG7_DP_CAPTURE_EN
        digit_dp[idx] <= ~seg_in[7];
`endif
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed self-checking bench for seg7_scan_reader (8 digits, settle 4)
module tb_seg7_scan_reader;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] seg_in;
  logic [7:0] dig_sel;
  logic [31:0] digit_val;
  logic [7:0] digit_ok;
  logic frame_valid, pat_err;
`ifdef SEG7_DP_CAPTURE_EN
  logic [7:0] digit_dp;
`endif
  int errors = 0;
  int checks = 0;
  int frames = 0;
  int fb;
  logic [6:0] pa[8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] pb[8] = '{7'h46, 7'h21, 7'h06, 7'h0E, 7'h40, 7'h79, 7'h24, 7'h30};
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_valid) frames++;
  seg7_scan_reader dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
    .digit_val(digit_val),
    .digit_ok(digit_ok),
    .frame_valid(frame_valid),
    .pat_err(pat_err)
`ifdef SEG7_DP_CAPTURE_EN
    ,
    .digit_dp(digit_dp)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic show(input int d, input logic [7:0] s, input int n);
    dig_sel = ~(8'b1 << d);
    seg_in = s;
    cyc(n);
  endtask
  task automatic idle(input int n);
    dig_sel = 8'hFF;
    seg_in = 8'hFF;
    cyc(n);
  endtask
  initial begin
    rst = 1'b1;
    dig_sel = 8'hFF;
    seg_in = 8'hFF;
    cyc(3);
    chk("rst_val", digit_val, 32'h0);
    chk("rst_ok", {24'h0, digit_ok}, 32'h0);
    chk("rst_fv", {31'h0, frame_valid}, 32'h0);
    chk("rst_perr", {31'h0, pat_err}, 32'h0);
    rst = 1'b0;
    idle(2);
    fb = frames;
    show(0, 8'h40, 6);
    for (int i = 1; i < 8; i++) show(i, {1'b1, pa[i]}, 6);
    idle(3);
    chk("scan1_val", digit_val, 32'h76543210);
    chk("scan1_ok", {24'h0, digit_ok}, 32'hFF);
    chk("scan1_frames", frames - fb, 1);
    chk("scan1_perr", {31'h0, pat_err}, 32'h0);
`ifdef SEG7_DP_CAPTURE_EN
    chk("scan1_dp", {24'h0, digit_dp}, 32'h01);
`endif
    show(2, 8'h80, 5);
    chk("glitch_pre", digit_val, 32'h76543810);
    show(2, 8'hA4, 3);
    chk("glitch_short", digit_val, 32'h76543810);
    show(2, 8'hB0, 3);
    chk("latency_3", digit_val, 32'h76543810);
    cyc(1);
    chk("latency_4", digit_val, 32'h76543310);
    show(5, 8'hD5, 6);
    chk("bad_ok", {24'h0, digit_ok}, 32'hDF);
    chk("bad_perr", {31'h0, pat_err}, 32'h1);
    chk("bad_val", digit_val, 32'h76543310);
    fb = frames;
    for (int i = 0; i < 8; i++) show(i, {1'b1, pa[i]}, 6);
    idle(3);
    chk("scan2_val", digit_val, 32'h76543210);
    chk("scan2_ok", {24'h0, digit_ok}, 32'hFF);
    chk("scan2_perr_sticky", {31'h0, pat_err}, 32'h1);
    chk("scan2_frames", frames - fb, 1);
    show(0, 8'h80, 6);
    show(1, 8'h90, 6);
    show(2, 8'hBF, 6);
    show(3, 8'hFF, 6);
    chk("part_val", digit_val, 32'h7654BA98);
    show(4, 8'h99, 3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_val", digit_val, 32'h0);
    chk("mid_rst_ok", {24'h0, digit_ok}, 32'h0);
    chk("mid_rst_perr", {31'h0, pat_err}, 32'h0);
    chk("mid_rst_fv", {31'h0, frame_valid}, 32'h0);
    cyc(3);
    chk("post_rst_settle", {24'h0, digit_ok}, 32'h0);
    cyc(1);
    chk("post_rst_cap_ok", {24'h0, digit_ok}, 32'h10);
    chk("post_rst_cap_val", digit_val, 32'h00040000);
    fb = frames;
    dig_sel = 8'hF3;
    seg_in = 8'hC0;
    cyc(20);
    chk("multi_sel_val", digit_val, 32'h00040000);
    chk("multi_sel_ok", {24'h0, digit_ok}, 32'h10);
    chk("multi_sel_perr", {31'h0, pat_err}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
`ifdef SEG7_DP_CAPTURE_EN
        show(1, 8'h21, 6);
`else
        show(1, 8'hA1, 2);
        show(1, 8'h21, 2);
        chk("dp_ignored", {28'h0, digit_val[7:4]}, 32'hD);
        cyc(2);
`endif
      end else show(i, {1'b1, pb[i]}, 6);
    end
    idle(3);
    chk("seven_frames", frames - fb, 0);
    chk("seven_ok", {24'h0, digit_ok}, 32'h7F);
    show(7, {1'b1, pb[7]}, 6);
    idle(3);
    chk("scan3_frames", frames - fb, 1);
    chk("scan3_val", digit_val, 32'h3210FEDC);
    chk("scan3_ok", {24'h0, digit_ok}, 32'hFF);
    chk("scan3_perr", {31'h0, pat_err}, 32'h0);
`ifdef SEG7_DP_CAPTURE_EN
    chk("scan3_dp", {24'h0, digit_dp}, 32'h02);
`endif
    show(0, 8'h40, 6);
    chk("dp_zero_val", digit_val, 32'h3210FED0);
`ifdef SEG7_DP_CAPTURE_EN
    chk("dp_zero_dp", {24'h0, digit_dp}, 32'h03);
`endif
    show(0, 8'hBF, 6);
    chk("dash_val", digit_val, 32'h3210FEDA);
    show(0, 8'h7F, 6);
    chk("blank_val", digit_val, 32'h3210FEDB);
    chk("final_perr", {31'h0, pat_err}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
